// File: rtl/seg_display_scan_if.sv
// Display-side bundle for seg_display_scan: datapath inputs and board pin outputs.
interface seg_display_scan_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] numb;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   mask;
  logic [DIGITS-1:0]   blink;
  logic                error;
  logic [3:0]          bright;
  logic [DIGITS-1:0]   anodes;
  logic [7:0]          cathodes;

  modport master (
    output numb, dp, mask, blink, error, bright,
    input  anodes, cathodes
  );

  modport slave (
    input  numb, dp, mask, blink, error, bright,
    output anodes, cathodes
  );
endinterface

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode 7-segment scanner with frame snapshot, blink,
// PWM brightness and a fixed "Err" message.
module seg_display_scan #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned SCAN_DIV_LOG2 = 10,
  parameter int unsigned BLINK_TICKS   = 24414
) (
  input logic              clk,
  input logic              rst,
  seg_display_scan_if.slave bus
);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [SCAN_DIV_LOG2-1:0] pre_cnt;
  logic [IDX_W-1:0]         idx;
  logic [BLINK_W-1:0]       blink_cnt;
  logic                     phase;

  logic [4*DIGITS-1:0] numb_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   mask_q;
  logic [DIGITS-1:0]   blink_q;
  logic                error_q;

  logic [DIGITS-1:0] anodes_q;
  logic [7:0]        cathodes_q;

  logic              tick_c;
  logic [DIGITS-1:0] anodes_d;
  logic [7:0]        cathodes_d;

  assign tick_c       = &pre_cnt;
  assign bus.anodes   = anodes_q;
  assign bus.cathodes = cathodes_q;

  function automatic logic [7:0] hex_font(input logic [3:0] n);
    logic [7:0] code;
    case (n)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Timebase, digit index, blink phase and frame-end snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      numb_q    <= '0;
      dp_q      <= '0;
      mask_q    <= '1;
      blink_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      if (tick_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        if (idx == IDX_LAST) begin
          numb_q  <= bus.numb;
          dp_q    <= bus.dp;
          mask_q  <= bus.mask;
          blink_q <= bus.blink;
          error_q <= bus.error;
        end
      end
    end
  end

  // Pin values for the current slot; anything not visible is fully dark.
  always_comb begin
    logic [3:0] nib;
    logic [7:0] font_code;
    logic       dp_sel;
    logic       mask_sel;
    logic       blink_sel;
    logic       en;
    logic       visible;

    nib        = '0;
    font_code  = 8'hFF;
    dp_sel     = 1'b0;
    mask_sel   = 1'b0;
    blink_sel  = 1'b0;
    visible    = 1'b0;
    anodes_d   = '1;
    cathodes_d = 8'hFF;

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = numb_q[4*i +: 4];
        dp_sel    = dp_q[i];
        mask_sel  = mask_q[i];
        blink_sel = blink_q[i];
      end
    end

    en = (pre_cnt[SCAN_DIV_LOG2-1 -: 4] <= bus.bright);

    if (error_q) begin
      if (en && !phase && (idx <= IDX_W'(2))) begin
        visible    = 1'b1;
        cathodes_d = (idx == IDX_W'(2)) ? 8'h86 : 8'hAF;
      end
    end else if (en && !mask_sel && !(blink_sel && phase)) begin
      visible    = 1'b1;
      font_code  = hex_font(nib);
      cathodes_d = {~dp_sel, font_code[6:0]};
    end

    if (visible) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        anodes_d[i] = (idx != IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes_q   <= '1;
      cathodes_q <= 8'hFF;
    end else begin
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with DIGITS=4, 16-clk slots, 3-tick blink.
module tb_seg_display_scan;
  localparam int unsigned DIGITS        = 4;
  localparam int unsigned SCAN_DIV_LOG2 = 4;
  localparam int unsigned BLINK_TICKS   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg_display_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_display_scan #(
    .DIGITS       (DIGITS),
    .SCAN_DIV_LOG2(SCAN_DIV_LOG2),
    .BLINK_TICKS  (BLINK_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Edges since reset release; after edge k the outputs show scan state k-1.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic adv_to(input int n);
    int guard = 0;
    @(negedge clk);
    while (k < n + 1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (k != n + 1) begin
      errors++;
      $display("FAIL sync: edge count %0d, wanted %0d", k, n + 1);
    end
  endtask

  task automatic test_reset();
    int         st [5] = '{0, 30, 63, 64, 70};
    logic [3:0] an [5] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
    logic [7:0] ca [5] = '{8'hFF, 8'hFF, 8'hFF, 8'h8E, 8'h8E};
    int         st2 [3] = '{0, 63, 64};
    logic [3:0] an2 [3] = '{4'hF, 4'hF, 4'hE};
    logic [7:0] ca2 [3] = '{8'hFF, 8'hFF, 8'h8E};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.anodes !== 4'hF || bus.cathodes !== 8'hFF) begin
      errors++;
      $display("FAIL reset_hold: got %h/%h, expected F/FF", bus.anodes, bus.cathodes);
    end
    @(negedge clk);
    bus.numb = 16'h12AF;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL reset_frame state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.anodes !== 4'hF || bus.cathodes !== 8'hFF) begin
      errors++;
      $display("FAIL reset_async: got %h/%h, expected F/FF", bus.anodes, bus.cathodes);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv_to(st2[i]);
      checks++;
      if (bus.anodes !== an2[i] || bus.cathodes !== ca2[i]) begin
        errors++;
        $display("FAIL reset_rerun state=%0d: got %h/%h, expected %h/%h",
                 st2[i], bus.anodes, bus.cathodes, an2[i], ca2[i]);
      end
    end
  endtask

  task automatic test_normal();
    int         st [7] = '{79, 80, 95, 96, 112, 127, 128};
    logic [3:0] an [7] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'h7, 4'h7, 4'hE};
    logic [7:0] ca [7] = '{8'h8E, 8'h88, 8'h88, 8'hA4, 8'hF9, 8'hF9, 8'h8E};
    for (int i = 0; i < 7; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL normal state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    int         st [6] = '{144, 160, 176, 192, 208, 240};
    logic [3:0] an [6] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'h7};
    logic [7:0] ca [6] = '{8'h88, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
    for (int i = 0; i < 6; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL snapshot state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
      if (i == 0) bus.numb = 16'h0000;
    end
    bus.numb = 16'h12AF;
    bus.dp   = 4'b0010;
    bus.mask = 4'b1000;
  endtask

  task automatic test_dp_mask();
    int         st [5] = '{256, 272, 288, 304, 319};
    logic [3:0] an [5] = '{4'hE, 4'hD, 4'hB, 4'hF, 4'hF};
    logic [7:0] ca [5] = '{8'h8E, 8'h08, 8'hA4, 8'hFF, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL dp_mask state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
    end
    bus.bright = 4'd3;
    bus.dp     = 4'b0000;
    bus.mask   = 4'b0000;
  endtask

  // bright is live; dp/mask of the 320 frame are still the old snapshot.
  task automatic test_bright();
    int         st [11] = '{320, 323, 324, 335, 336, 339, 340, 352, 353, 384, 385};
    logic [3:0] an [11] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hF, 4'hB, 4'hF, 4'hE, 4'hF};
    logic [7:0] ca [11] = '{8'h8E, 8'h8E, 8'hFF, 8'hFF, 8'h08, 8'h08, 8'hFF,
                            8'hA4, 8'hFF, 8'h8E, 8'hFF};
    for (int i = 0; i < 11; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL bright state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
      if (st[i] == 340) bus.bright = 4'd0;
    end
    bus.bright = 4'd15;
    bus.blink  = 4'b0001;
  endtask

  // Slot T has phase = (T/3) mod 2; error snapshot lands on the T47 tick with a phase toggle.
  task automatic test_blink_error();
    int         st [16] = '{448, 464, 512, 640, 656, 704, 720, 752,
                            768, 784, 800, 816, 832, 848, 864, 880};
    logic [3:0] an [16] = '{4'hF, 4'hD, 4'hE, 4'hF, 4'hD, 4'hE, 4'hD, 4'h7,
                            4'hE, 4'hD, 4'hB, 4'hF, 4'hF, 4'hF, 4'hB, 4'hF};
    logic [7:0] ca [16] = '{8'hFF, 8'h88, 8'h8E, 8'hFF, 8'h88, 8'h8E, 8'h88, 8'hF9,
                            8'hAF, 8'hAF, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'h86, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      adv_to(st[i]);
      checks++;
      if (bus.anodes !== an[i] || bus.cathodes !== ca[i]) begin
        errors++;
        $display("FAIL blink_error state=%0d: got %h/%h, expected %h/%h",
                 st[i], bus.anodes, bus.cathodes, an[i], ca[i]);
      end
      if (st[i] == 720) bus.error = 1'b1;
    end
  endtask

  initial begin
    bus.numb   = '0;
    bus.dp     = '0;
    bus.mask   = '0;
    bus.blink  = '0;
    bus.error  = 1'b0;
    bus.bright = 4'hF;
    test_reset();
    test_normal();
    test_snapshot();
    test_dp_mask();
    test_bright();
    test_blink_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised multiplexed 7-segment display driver; next generation of the board's 8-digit hex scanner.
- Scans DIGITS common-anode digits and shows a hex value with per-digit decimal points, blanking mask and blink mask.
- Adds 16-level PWM brightness, a built-in "Err" error mode, and a frame-synchronous input snapshot so the display never tears.
- Sits between the datapath and the board anode/cathode pins.

Parameters:
DIGITS, 8, number of digits scanned; legal range 3..16.
SCAN_DIV_LOG2, 10, log2 of clocks per digit slot (SCAN_DIV = 2**SCAN_DIV_LOG2); legal range 4..20.
BLINK_TICKS, 24414, scan ticks per blink half-period; must be 1 or greater.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
numb  in  4*DIGITS  hex nibbles; nibble k (numb[4k+3:4k]) drives digit k.
dp  in  DIGITS  decimal point per digit; 1 = lit.
mask  in  DIGITS  1 = digit blanked.
blink  in  DIGITS  1 = digit blinks.
error  in  1  1 = show "Err".
bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
anodes  out  DIGITS  active-low digit enables.
cathodes  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, immediate):
  - anodes = all 1s, cathodes = 8'hFF.
  - pre_cnt = 0, idx = 0, blink_cnt = 0, phase = 0.
  - Shadow regs: numb/dp/blink/error = 0; mask = all 1s, so the first frame after reset is blank.
- Prescaler pre_cnt counts 0..SCAN_DIV-1 and wraps. tick = (pre_cnt == SCAN_DIV-1).
- On tick, idx increments, wrapping DIGITS-1 -> 0.
- Snapshot: on a tick with idx == DIGITS-1 (frame end), shadow regs load numb, dp, mask, blink and error. Input changes mid-frame are invisible until the next frame.
- Blink: blink_cnt counts ticks 0..BLINK_TICKS-1. On wrap, phase toggles.
- Slot enable: en = (pre_cnt[SCAN_DIV_LOG2-1 -: 4] <= bright). bright=15 gives always on; bright=b gives (b+1)/16 of each slot.
- Normal mode (shadow error = 0):
  - Digit idx is visible iff en, mask[idx] = 0, and NOT (blink[idx] and phase).
  - Segments use the hex font: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. These codes are for dp off.
  - cathodes[7] = ~dp[idx].
- Error mode (shadow error = 1):
  - Digit 2 = 8'h86 (E), digits 1 and 0 = 8'hAF (r); digits >= 3 are blank.
  - dp, mask and blink are ignored. The whole display blanks when phase = 1. PWM still applies.
- Invisible digit: anodes = all 1s and cathodes = 8'hFF (anti-ghosting).
- Visible digit: anodes = ~(1 << idx).
- Latency: outputs are registered. Values in cycle t+1 are a function of pre_cnt, idx, phase and shadows in cycle t.
- Boundaries:
  - Frame-end snapshot and blink-phase toggle on the same tick both take effect; the new phase applies to the new frame.
  - rst asserted mid-slot clears everything; no partial slot completes.

Test Plan:
Use DIGITS=4, SCAN_DIV_LOG2=4, BLINK_TICKS=3 (slot = 16 clk, frame = 64 clk).
1. Reset:
   - Pulse rst mid-slot -> anodes 4'hF, cathodes 8'hFF in the same cycle, without waiting for a clk edge.
   - After release -> first 64 clk blank, then digits appear.
2. Normal display:
   - numb=16'h12AF, mask=0, dp=0, bright=15, blink=0.
   - Slots give (anodes/cathodes): 1110/8E, 1101/88, 1011/A4, 0111/F9, each held 16 clk, repeating.
3. Snapshot:
   - Change numb to 16'h0000 while slot 1 is showing -> slots 2 and 3 still show 2 and 1.
   - Next frame shows C0 on all digits.
4. Decimal point and mask:
   - dp=4'b0010 -> slot 1 cathodes = 8'h08.
   - mask=4'b1000 -> slot 3 gives anodes 4'hF, cathodes 8'hFF.
5. Brightness:
   - bright=3 -> in each slot the anode is low for pre_cnt 0..3, then anodes F / cathodes FF for the remaining 12 clk.
   - bright=0 -> low 1 clk per slot.
6. Blink and error:
   - blink=4'b0001 -> digit 0 visible for 3 ticks, blank for 3 ticks, alternating; digits 1..3 unaffected.
   - error=1 -> slots 2/1/0 show 86/AF/AF, slot 3 blank; all digits blank together while phase = 1.
